control_fsm: RTL and testbench

Multi-cycle control unit for the single-ported RV64I core. Sequences every instruction through fetch, decode, execute, memory and writeback, and drives all datapath selects: ALU operand muxes, immediate usage, PC update, register-file write enable and the shared memory request. Sits beside the datapath. Memory is a single port shared between instruction fetch and data access, with a ready handshake guarded by a wait-timeout counter.

---
 rtl/control_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_control_fsm.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle fetch/decode/exec/mem/writeback sequencer for the
// single-ported RV64I datapath; the memory port is shared between fetch and
// data access, and every memory wait is bounded by MEM_WAIT_MAX.
// Optional feature macro: CONTROL_FSM_ILLEGAL_EN traps unknown opcodes in the
// ILLEGAL state and adds the sticky o_illegal output.
module control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_branch_taken,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_is_fetch,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic [1:0]  o_pc_src,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic        o_reg_write,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_state,
  output logic        o_mem_timeout
`ifdef CONTROL_FSM_ILLEGAL_EN
  ,
  output logic        o_illegal
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_UJ   = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`ifdef CONTROL_FSM_ILLEGAL_EN
  logic               illegal_q, illegal_d;
`endif

  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic             op_known;
  logic [CNT_W-1:0] cnt_inc;
  logic             wait_last;
  logic             unused_instr_hi;

  // Instruction fields and wait-budget decode
  assign opcode          = i_instr[6:0];
  assign rd              = i_instr[11:7];
  assign unused_instr_hi = ^i_instr[31:12];
  assign op_known        = (opcode == OP_R)  || (opcode == OP_ADDI) || (opcode == OP_LD)   ||
                           (opcode == OP_S)  || (opcode == OP_SB)   || (opcode == OP_JALR) ||
                           (opcode == OP_U)  || (opcode == OP_UJ);
  assign cnt_inc         = cnt_q + CNT_W'(1);
  // This wait cycle is the last one allowed; ready in the same cycle still wins
  assign wait_last       = (cnt_inc == CNT_W'(MEM_WAIT_MAX));

  // State, wait counter and sticky flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef CONTROL_FSM_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef CONTROL_FSM_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
`ifdef CONTROL_FSM_ILLEGAL_EN
    illegal_d      = illegal_q;
`endif
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_is_fetch = 1'b0;
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_src       = 2'd0;
    o_alu_src_a    = 1'b0;
    o_alu_src_b    = 2'd0;
    o_alu_op       = 2'd0;
    o_reg_write    = 1'b0;
    o_wb_sel       = 2'd0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        o_mem_req      = 1'b1;
        o_mem_is_fetch = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_last) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DECODE: begin
        if (op_known) begin
          state_d = S_EXEC;
        end else begin
`ifdef CONTROL_FSM_ILLEGAL_EN
          state_d   = S_ILLEGAL;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            o_alu_op = 2'd2;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            o_alu_src_b = 2'd1;
            o_alu_op    = 2'd2;
            state_d     = S_WB;
          end
          OP_LD, OP_S: begin
            o_alu_src_b = 2'd1;
            state_d     = S_MEM;
          end
          OP_SB: begin
            o_alu_op = 2'd1;
            if (i_branch_taken) begin
              o_pc_write = 1'b1;
              o_pc_src   = 2'd1;
            end
            state_d = S_FETCH;
          end
          OP_JALR: begin
            o_alu_src_b = 2'd1;
            o_pc_write  = 1'b1;
            o_pc_src    = 2'd2;
            state_d     = S_WB;
          end
          OP_UJ: begin
            o_pc_write = 1'b1;
            o_pc_src   = 2'd1;
            state_d    = S_WB;
          end
          OP_U:    state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (opcode == OP_S);
        if (i_mem_ready) begin
          state_d = (opcode == OP_LD) ? S_WB : S_FETCH;
        end else if (wait_last) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WB: begin
        o_reg_write = (rd != 5'd0);
        case (opcode)
          OP_LD:          o_wb_sel = 2'd1;
          OP_JALR, OP_UJ: o_wb_sel = 2'd2;
          OP_U:           o_wb_sel = 2'd3;
          default:        o_wb_sel = 2'd0;
        endcase
        state_d = S_FETCH;
      end

      S_HALT:    state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase

    // Every entry into a new state restarts the wait budget
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign o_state       = state_q;
  assign o_mem_timeout = timeout_q;
`ifdef CONTROL_FSM_ILLEGAL_EN
  assign o_illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized scoreboard bench for control_fsm. A phase-level
// reference model expands each instruction into its expected per-cycle control
// record; the driver pushes records as it applies stimulus and a negedge
// monitor pops and compares them against the DUT outputs.
module tb_control_fsm;

  localparam int MAX = 16;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_LD   = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_SB   = 7'h63;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_U    = 7'h37;
  localparam logic [6:0] OP_UJ   = 7'h6F;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       isf;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       rw;
    logic [1:0] wb;
    logic       to;
    logic       il;
  } rec_t;

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic        tk;
    rec_t        e;
  } step_t;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_instr;
  logic        i_branch_taken;
  logic        i_mem_ready;
  logic        o_mem_req, o_mem_we, o_mem_is_fetch, o_ir_write, o_pc_write;
  logic [1:0]  o_pc_src;
  logic        o_alu_src_a;
  logic [1:0]  o_alu_src_b, o_alu_op;
  logic        o_reg_write;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_state;
  logic        o_mem_timeout;
`ifdef CONTROL_FSM_ILLEGAL_EN
  logic        o_illegal;
`endif

  int    errors = 0;
  int    checks = 0;
  int    mon_n  = 0;
  rec_t  mon_e;
  step_t plan_q[$];
  rec_t  exp_q[$];

  control_fsm #(.MEM_WAIT_MAX(MAX)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_instr        (i_instr),
    .i_branch_taken (i_branch_taken),
    .i_mem_ready    (i_mem_ready),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_is_fetch (o_mem_is_fetch),
    .o_ir_write     (o_ir_write),
    .o_pc_write     (o_pc_write),
    .o_pc_src       (o_pc_src),
    .o_alu_src_a    (o_alu_src_a),
    .o_alu_src_b    (o_alu_src_b),
    .o_alu_op       (o_alu_op),
    .o_reg_write    (o_reg_write),
    .o_wb_sel       (o_wb_sel),
    .o_state        (o_state),
    .o_mem_timeout  (o_mem_timeout)
`ifdef CONTROL_FSM_ILLEGAL_EN
    ,
    .o_illegal      (o_illegal)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic rec_t act();
    rec_t r;
    r.st  = o_state;
    r.req = o_mem_req;
    r.we  = o_mem_we;
    r.isf = o_mem_is_fetch;
    r.irw = o_ir_write;
    r.pcw = o_pc_write;
    r.pcs = o_pc_src;
    r.a   = o_alu_src_a;
    r.b   = o_alu_src_b;
    r.op  = o_alu_op;
    r.rw  = o_reg_write;
    r.wb  = o_wb_sel;
    r.to  = o_mem_timeout;
`ifdef CONTROL_FSM_ILLEGAL_EN
    r.il  = o_illegal;
`else
    r.il  = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input rec_t a, input rec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h (req we isf irw pcw pcs a b op rw wb to il)",
               nm, a.st, a, e.st, e);
    end
  endtask

  // Scoreboard monitor: one expected record per driven cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n++;
      chk($sformatf("cycle%0d_state%0d", mon_n, mon_e.st), act(), mon_e);
    end
  end

  // ---- reference model: expected control record per phase ----
  function automatic rec_t rz(input logic [2:0] st);
    rec_t r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic rec_t fetch_rec(input logic rdy);
    rec_t r = rz(3'd1);
    r.req = 1'b1;
    r.isf = 1'b1;
    r.irw = rdy;
    r.pcw = rdy;
    return r;
  endfunction

  function automatic rec_t mem_rec(input logic store);
    rec_t r = rz(3'd4);
    r.req = 1'b1;
    r.we  = store;
    return r;
  endfunction

  task automatic add(input logic [31:0] instr, input logic rdy, input logic tk, input rec_t e);
    step_t s;
    s.instr = instr;
    s.rdy   = rdy;
    s.tk    = tk;
    s.e     = e;
    plan_q.push_back(s);
  endtask

  // A memory access with w wait cycles; w >= MAX exhausts the budget and halts
  task automatic add_wait(input logic [31:0] instr, input int w, input bit fetch,
                          input logic store, output bit halted);
    rec_t h = rz(3'd6);
    h.to   = 1'b1;
    halted = 1'b0;
    if (w >= MAX) begin
      for (int i = 0; i < MAX; i++) add(instr, 1'b0, rb(), fetch ? fetch_rec(1'b0) : mem_rec(store));
      for (int i = 0; i < 3; i++) add(instr, rb(), rb(), h);
      halted = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) add(instr, 1'b0, rb(), fetch ? fetch_rec(1'b0) : mem_rec(store));
      add(instr, 1'b1, rb(), fetch ? fetch_rec(1'b1) : mem_rec(store));
    end
  endtask

  task automatic build(input logic [31:0] instr, input int fw, input int mw,
                       input logic tk, output bit term);
    logic [6:0] op;
    logic [4:0] rd;
    bit         h;
    rec_t       e;
    op   = instr[6:0];
    rd   = instr[11:7];
    term = 1'b0;
    add_wait(instr, fw, 1'b1, 1'b0, h);
    if (h) begin
      term = 1'b1;
      return;
    end
    add(instr, rb(), rb(), rz(3'd2));
    if (!(op inside {OP_R, OP_ADDI, OP_LD, OP_S, OP_SB, OP_JALR, OP_U, OP_UJ})) begin
`ifdef CONTROL_FSM_ILLEGAL_EN
      e    = rz(3'd7);
      e.il = 1'b1;
      for (int i = 0; i < 3; i++) add(instr, rb(), rb(), e);
      term = 1'b1;
`endif
      return;
    end
    e = rz(3'd3);
    case (op)
      OP_R:        e.op = 2'd2;
      OP_ADDI:     begin e.b = 2'd1; e.op = 2'd2; end
      OP_LD, OP_S: e.b = 2'd1;
      OP_SB:       begin e.op = 2'd1; e.pcw = tk; e.pcs = tk ? 2'd1 : 2'd0; end
      OP_JALR:     begin e.b = 2'd1; e.pcw = 1'b1; e.pcs = 2'd2; end
      OP_UJ:       begin e.pcw = 1'b1; e.pcs = 2'd1; end
      default:     ;
    endcase
    add(instr, rb(), tk, e);
    if (op == OP_SB) return;
    if (op == OP_LD || op == OP_S) begin
      add_wait(instr, mw, 1'b0, (op == OP_S), h);
      if (h) begin
        term = 1'b1;
        return;
      end
      if (op == OP_S) return;
    end
    e    = rz(3'd5);
    e.rw = (rd != 5'd0);
    case (op)
      OP_LD:          e.wb = 2'd1;
      OP_JALR, OP_UJ: e.wb = 2'd2;
      OP_U:           e.wb = 2'd3;
      default:        e.wb = 2'd0;
    endcase
    add(instr, rb(), rb(), e);
  endtask

  // ---- driver ----
  task automatic run_plan(input bit abort_in_mem);
    step_t s;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      @(posedge clk);
      #1;
      i_instr        = s.instr;
      i_mem_ready    = s.rdy;
      i_branch_taken = s.tk;
      exp_q.push_back(s.e);
      if (abort_in_mem && s.e.st == 3'd4) begin
        plan_q.delete();
        break;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input bit mid_mem);
    rec_t r;
    @(posedge clk);
    #1;
    if (mid_mem) begin
      i_mem_ready = 1'b0;
      #1;
      r     = mem_rec(1'b0);
      chk("pre_reset_mid_mem", act(), r);
    end
    i_reset     = 1'b1;
    i_mem_ready = 1'b1;
    #1;
    chk("reset_async", act(), rz(3'd0));
    @(posedge clk);
    #1;
    chk("reset_held", act(), rz(3'd0));
    i_reset = 1'b0;
    exp_q.push_back(rz(3'd0));
  endtask

  task automatic one(input logic [31:0] instr, input int fw, input int mw, input logic tk);
    bit term;
    build(instr, fw, mw, tk, term);
    run_plan(1'b0);
    if (term) begin
      drain();
      do_reset(1'b0);
    end
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 39);
    if (r < 30) return r % 4;
    if (r < 38) return $urandom_range(4, MAX - 1);
    if (r == 38) return MAX - 1;
    return MAX;
  endfunction

  initial begin
    logic [31:0] ins;
    logic [6:0]  ops [10];
    bit          term;
    ops = '{OP_R, OP_ADDI, OP_LD, OP_S, OP_SB, OP_JALR, OP_U, OP_UJ, 7'h7F, OP_LD};

    i_reset        = 1'b1;
    i_instr        = '0;
    i_branch_taken = 1'b0;
    i_mem_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_init", act(), rz(3'd0));
    i_reset = 1'b0;
    exp_q.push_back(rz(3'd0));

    // ADDI x5, zero-wait memory
    ins = 32'h0050_0293;
    one(ins, 0, 0, 1'b0);
    // LD with three wait cycles in MEM
    ins = 32'h0001_3103;
    one(ins, 0, 3, 1'b0);
    // Branch taken then not taken
    ins = 32'h0020_8463;
    one(ins, 0, 0, 1'b1);
    one(ins, 0, 0, 1'b0);
    // ADDI with rd=0 never writes the register file
    ins = 32'h0010_0013;
    one(ins, 1, 0, 1'b0);
    // Fetch ready arrives on the last allowed wait cycle
    ins = 32'h0050_0293;
    one(ins, MAX - 1, 0, 1'b0);
    // Store, JALR, LUI, JAL
    ins = 32'h0021_3423;
    one(ins, 0, 2, 1'b0);
    ins = 32'h0000_80E7;
    one(ins, 0, 0, 1'b0);
    ins = 32'h1234_52B7;
    one(ins, 2, 0, 1'b0);
    ins = 32'h0100_00EF;
    one(ins, 0, 0, 1'b0);
    // Unknown opcode 0x7F
    ins = 32'h0000_02FF;
    one(ins, 0, 0, 1'b0);

    // Reset while a load waits in MEM
    ins = 32'h0001_3103;
    build(ins, 0, 3, 1'b0, term);
    run_plan(1'b1);
    drain();
    do_reset(1'b1);

    // Fetch never answered: timeout into HALT
    ins = 32'h0050_0293;
    one(ins, MAX, 0, 1'b0);

    // Randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      ins      = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      if (ins[6:0] == 7'h7F && rb()) ins[6:0] = 7'h73;
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      one(ins, pick_wait(), pick_wait(), rb());
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
